tri_bus_arbiter: RTL and testbench
==================================

TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one tri-state bus.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive cycles one owner may hold the bus.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N  per-requester bus request, level-sensitive.
REQ-006 fault  input  N  per-driver fault flag (the faultactive of that driver's breakable buffer); a faulted requester is ineligible.
REQ-007 en  output  N  registered one-hot-or-zero enables, one per tri-state buffer driving the bus.
REQ-008 grant_id  output  clog2(N)  index of the current owner; holds last owner when en is zero.
REQ-009 busy  output  1  high while any en bit is high.
REQ-010 timeout  output  1  one-cycle pulse when an owner is revoked for reaching MAX_HOLD.

Function
REQ-011 en SHALL never have more than one bit set in any cycle, including during transitions.
REQ-012 States: IDLE, GRANT, TURN (turnaround); encoding 2 bits.
REQ-013 Eligible vector = req & ~fault.
REQ-014 IDLE: if eligible nonzero at an edge, pick winner round-robin starting at (last_owner+1) mod N; the same edge sets en[winner], grant_id=winner, last_owner=winner, hold_cnt=1, and enters GRANT.
REQ-015 IDLE with eligible zero: remain IDLE, en=0.
REQ-016 Request-to-enable latency SHALL be exactly one edge from IDLE.
REQ-017 GRANT: stay while req[owner]=1, fault[owner]=0, and hold_cnt<MAX_HOLD; increment hold_cnt (saturating at MAX_HOLD) each cycle.
REQ-018 GRANT exits to TURN, clearing en on the same edge, when req[owner] drops, fault[owner] rises, or hold_cnt=MAX_HOLD.
REQ-019 Exit because hold_cnt=MAX_HOLD with req[owner] still high SHALL pulse timeout for exactly the TURN cycle.
REQ-020 Simultaneous fault and timeout: treat as fault; no timeout pulse.
REQ-021 TURN lasts exactly one cycle with en=0, then IDLE; guarantees one bus-idle (all-Z) cycle between owners.
REQ-022 Round-robin SHALL skip faulted requesters; a requester with req held continuously is granted within N grants.
REQ-023 Owner revoked by timeout SHALL not be re-granted next if another requester is eligible (follows from REQ-014).
REQ-024 Requests or faults changing during TURN SHALL only take effect at the IDLE arbitration edge.
REQ-025 All fault bits set: no grant ever; en stays 0.

Reset
REQ-026 rst_n low SHALL asynchronously force en=0, busy=0, timeout=0, grant_id=0, state=IDLE, hold_cnt=0, last_owner=N-1 (requester 0 first priority).
REQ-027 Reset asserted mid-GRANT SHALL drop en immediately, without waiting for clk.
REQ-028 First arbitration SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-029 State encodings, default N and MAX_HOLD SHALL reside in shared package tri_bus_pkg.
REQ-030 The round-robin priority picker SHALL be a combinational sub-module rr_pick (inputs eligible, last_owner; outputs winner, found).
REQ-031 en, busy, timeout, grant_id SHALL be driven directly from flops.

Verification
REQ-032 Reset release, req=4'b0100 held -> en=4'b0100 one edge later, grant_id=2, busy=1.
REQ-033 req=4'b1111 held, MAX_HOLD=8 -> owners 0,1,2,3,0 in order; each en high 8 cycles, then 1 TURN cycle with en=0 and timeout=1.
REQ-034 Owner 1 granted, fault[1] rises mid-grant -> en=0 next edge, no timeout; with req=4'b1010 next grant goes to 3.
REQ-035 req[0] pulsed 3 cycles, req[1] held -> en=0001 for 3 cycles, 1 all-zero cycle, then en=0010.
REQ-036 rst_n pulled low between edges during grant -> en=0 immediately; after release with req=4'b1000 -> en=1000 next edge.
REQ-037 Every scenario: assertion that en is one-hot-or-zero each cycle and every owner change is separated by at least one en=0 cycle.

Source files
------------

// File: rtl/tri_bus_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM encoding and default sizing.
package tri_bus_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after last_owner, wrapping mod N.
// Zero latency; found is low when nothing is eligible.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] last_owner,
  output logic [W-1:0] winner,
  output logic         found
);

  // Scan from farthest to nearest so the nearest eligible index is written last and wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = N; i >= 1; i--) begin
      int idx;
      idx = (int'(last_owner) + i) % N;
      if (eligible[idx]) begin
        winner = W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Arbitrates N tri-state drivers onto one bus; enables are registered, one edge after request.
// Owners are revoked on release, fault or MAX_HOLD; one all-Z cycle always separates owners.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] fault,
  output logic [N-1:0] en,
  output logic [W-1:0] grant_id,
  output logic         busy,
  output logic         timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t         state, state_nxt;
  logic [HW-1:0]  hold_cnt, hold_nxt;
  logic [W-1:0]   last_owner, last_nxt;
  logic [N-1:0]   en_nxt;
  logic [W-1:0]   grant_nxt;
  logic           busy_nxt, timeout_nxt;

  logic [N-1:0]   eligible;
  logic [W-1:0]   winner;
  logic           found;
  logic           owner_req, owner_flt, hold_max;

  assign eligible  = req & ~fault;
  assign owner_req = req[grant_id];
  assign owner_flt = fault[grant_id];
  assign hold_max  = (hold_cnt >= HW'(MAX_HOLD));

  rr_pick #(.N(N), .W(W)) u_pick (
    .eligible   (eligible),
    .last_owner (last_owner),
    .winner     (winner),
    .found      (found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      en         <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= W'(N - 1);
    end else begin
      state      <= state_nxt;
      en         <= en_nxt;
      grant_id   <= grant_nxt;
      busy       <= busy_nxt;
      timeout    <= timeout_nxt;
      hold_cnt   <= hold_nxt;
      last_owner <= last_nxt;
    end
  end

  // The edge closing TURN is itself an arbitration edge, so exactly one all-Z cycle
  // separates consecutive owners; with nothing eligible the FSM parks in IDLE.
  always_comb begin
    state_nxt   = state;
    en_nxt      = en;
    grant_nxt   = grant_id;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    hold_nxt    = hold_cnt;
    last_nxt    = last_owner;

    case (state)
      GRANT: begin
        if (owner_flt || !owner_req || hold_max) begin
          state_nxt   = TURN;
          en_nxt      = '0;
          busy_nxt    = 1'b0;
          timeout_nxt = hold_max && owner_req && !owner_flt;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: begin
        if (found) begin
          state_nxt        = GRANT;
          en_nxt           = '0;
          en_nxt[winner]   = 1'b1;
          grant_nxt        = winner;
          last_nxt         = winner;
          hold_nxt         = HW'(1);
          busy_nxt         = 1'b1;
        end else begin
          state_nxt = IDLE;
          en_nxt    = '0;
          busy_nxt  = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (N=4, MAX_HOLD=8): vector table plus reset, timeout and fault sequences.
module tb_tri_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] fault;
  logic [3:0] en;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int n_chk;
  int n_fail;
  logic [3:0] prev_en;

  tri_bus_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .fault    (fault),
    .en       (en),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] fault;
    logic [3:0] en;
    logic [1:0] gid;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic [3:0] r, logic [3:0] f, logic [3:0] e,
                              logic [1:0] g, logic b, logic t);
    vec_t v;
    v.req = r; v.fault = f; v.en = e; v.gid = g; v.busy = b; v.to = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive inputs away from the edge, advance one edge, then check bus-safety properties.
  task automatic step(input logic [3:0] r, input logic [3:0] f);
    req   = r;
    fault = f;
    @(posedge clk);
    #1;
    chk("en_onehot0", {31'd0, $onehot0(en)}, 32'd1);
    chk("owner_gap", {31'd0, (prev_en != 4'd0 && en != 4'd0 && en != prev_en)}, 32'd0);
    prev_en = en;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e, input logic [1:0] g,
                            input logic b, input logic t);
    chk({tag, ".en"}, {28'd0, en}, {28'd0, e});
    chk({tag, ".grant_id"}, {30'd0, grant_id}, {30'd0, g});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, t});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    prev_en = 4'd0;
    rst_n   = 1'b0;
    req     = 4'd0;
    fault   = 4'd0;

    //             req      fault    en       gid   busy  to
    tbl[0]  = mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    tbl[1]  = mk(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    tbl[2]  = mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
    tbl[3]  = mk(4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
    tbl[4]  = mk(4'b1010, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
    tbl[5]  = mk(4'b1010, 4'b0010, 4'b1000, 2'd3, 1'b1, 1'b0);
    tbl[6]  = mk(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
    tbl[7]  = mk(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
    tbl[8]  = mk(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    tbl[9]  = mk(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    tbl[10] = mk(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    tbl[11] = mk(4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    tbl[12] = mk(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
    tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    tbl[14] = mk(4'b0000, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0);
    tbl[15] = mk(4'b1111, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0);
    tbl[16] = mk(4'b1111, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0);
    tbl[17] = mk(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].req, tbl[i].fault);
      expect_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].gid, tbl[i].busy, tbl[i].to);
    end

    // Asynchronous reset in the middle of a grant.
    step(4'b0001, 4'b0000);
    expect_out("pre_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    prev_en = en;
    req = 4'b1000;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(4'b1000, 4'b0000);
    expect_out("post_rst", 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b0000, 4'b0000);
    expect_out("post_rst_turn", 4'b0000, 2'd3, 1'b0, 1'b0);
    step(4'b0000, 4'b0000);

    // All requesting: each owner holds 8 cycles, then one TURN cycle with timeout.
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8; c++) begin
        step(4'b1111, 4'b0000);
        expect_out($sformatf("rr%0d_c%0d", k, c), 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
      end
      step(4'b1111, 4'b0000);
      expect_out($sformatf("rr%0d_turn", k), 4'b0000, 2'(k % 4), 1'b0, 1'b1);
    end

    // Fault arriving on the same edge as the hold limit: revoke without timeout.
    for (int c = 0; c < 8; c++) begin
      step(4'b0001, 4'b0000);
      expect_out($sformatf("ft_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(4'b0001, 4'b0001);
    expect_out("ft_turn", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000);
    expect_out("ft_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
